// File: rtl/register_file_sb.sv
// Multi-port register file with a per-register pending scoreboard and a sequential clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted writes onto the read ports.
module register_file_sb #(
  parameter int unsigned REG_WIDTH       = 32,
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned ADDR_WIDTH      = $clog2(NUM_REGS),
  parameter int unsigned NUM_READ        = 2,
  parameter int unsigned NUM_WRITE       = 1,
  parameter int unsigned REG_ZERO_GROUND = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*REG_WIDTH-1:0]  wr_data,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*REG_WIDTH-1:0]   rd_data,
  output logic [NUM_READ-1:0]             rd_pending,
  input  logic                            issue_en,
  input  logic [ADDR_WIDTH-1:0]           issue_addr,
  input  logic                            clear_req,
  output logic                            clear_busy,
  output logic                            ready
);

  localparam logic [ADDR_WIDTH:0]   NumRegsW = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [REG_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [REG_WIDTH-1:0]  regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q, pend_d;

  logic [ADDR_WIDTH-1:0] wa    [NUM_WRITE];
  logic [REG_WIDTH-1:0]  wd    [NUM_WRITE];
  logic                  wr_ok [NUM_WRITE];
  logic                  issue_ok;

  // Out-of-range addresses and the grounded register behave as if absent.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic ok;
    ok = ({1'b0, a} < NumRegsW);
    if (REG_ZERO_GROUND != 0 && a == '0) ok = 1'b0;
    return ok;
  endfunction

  assign ready      = (state_q == StIdle);
  assign clear_busy = (state_q == StClear);

  for (genvar p = 0; p < NUM_WRITE; p++) begin : g_wr
    assign wa[p]    = wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd[p]    = wr_data[p*REG_WIDTH +: REG_WIDTH];
    assign wr_ok[p] = wr_en[p] && ready && addr_ok(wa[p]);
  end

  assign issue_ok = issue_en && ready && addr_ok(issue_addr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        // Ascending port order lets the highest port win; issue is applied last so it wins.
        for (int p = 0; p < NUM_WRITE; p++) begin
          if (wr_ok[p]) begin
            regs_d[wa[p]] = wd[p];
            pend_d[wa[p]] = 1'b0;
          end
        end
        if (issue_ok) pend_d[issue_addr] = 1'b1;
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        regs_d[cnt_q] = '0;
        pend_d[cnt_q] = 1'b0;
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [REG_WIDTH-1:0]  rdat;
    logic                  rpend;
`ifdef REGFILE_BYPASS_EN
    logic                  hit;
`endif

    assign ra = rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rdat  = '0;
      rpend = 1'b0;
      if (addr_ok(ra)) begin
        rdat  = regs_q[ra];
        rpend = pend_q[ra];
      end
`ifdef REGFILE_BYPASS_EN
      hit = 1'b0;
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (wr_ok[p] && wa[p] == ra) begin
          rdat  = wd[p];
          rpend = 1'b0;
          hit   = 1'b1;
        end
      end
      if (hit && issue_ok && issue_addr == ra) rpend = 1'b1;
`endif
    end

    assign rd_data[r*REG_WIDTH +: REG_WIDTH] = rdat;
    assign rd_pending[r]                     = rpend;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed table, hand-written clear/reset sequences
// and randomized traffic against an array/queue reference model.
module tb_register_file_sb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        clear_req;
  logic        clear_busy;
  logic        ready;

  register_file_sb #(
    .REG_WIDTH      (32),
    .NUM_REGS       (32),
    .NUM_READ       (2),
    .NUM_WRITE      (2),
    .REG_ZERO_GROUND(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_pending(rd_pending),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural contents plus a queue of registers still to be cleared.
  logic [31:0] mregs [32];
  logic        mpend [32];
  int          clr_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    return clr_q.size() != 0;
  endfunction

  task automatic exp_rd(input logic [4:0] a, output logic [31:0] d, output logic p);
    logic hit;
    d = (a == 0) ? 32'h0 : mregs[a];
    p = (a == 0) ? 1'b0 : mpend[a];
    hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (!m_busy() && a != 0) begin
      for (int q = 0; q < 2; q++) begin
        if (wr_en[q] && wr_addr[q*5 +: 5] == a) begin
          d   = wr_data[q*32 +: 32];
          p   = 1'b0;
          hit = 1'b1;
        end
      end
      if (hit && issue_en && issue_addr == a) p = 1'b1;
    end
`endif
  endtask

  task automatic model_edge();
    int idx;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] = '0;
        mpend[i] = 1'b0;
      end
      clr_q.delete();
    end else if (m_busy()) begin
      idx = clr_q.pop_front();
      mregs[idx] = '0;
      mpend[idx] = 1'b0;
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (wr_en[q] && wr_addr[q*5 +: 5] != 0) begin
          mregs[wr_addr[q*5 +: 5]] = wr_data[q*32 +: 32];
          mpend[wr_addr[q*5 +: 5]] = 1'b0;
        end
      end
      if (issue_en && issue_addr != 0) mpend[issue_addr] = 1'b1;
      if (clear_req) for (int i = 0; i < 32; i++) clr_q.push_back(i);
    end
  endtask

  task automatic sample();
    logic [31:0] ed;
    logic        ep;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      exp_rd(rd_addr[r*5 +: 5], ed, ep);
      chk($sformatf("rd_data%0d[r%0d]", r, rd_addr[r*5 +: 5]), rd_data[r*32 +: 32], ed);
      chk($sformatf("rd_pending%0d[r%0d]", r, rd_addr[r*5 +: 5]), 32'(rd_pending[r]),
          32'(ep));
    end
    chk("ready", 32'(ready), 32'(!m_busy()));
    chk("clear_busy", 32'(clear_busy), 32'(m_busy()));
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    issue_en  = 1'b0;
    issue_addr = '0;
    clear_req = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 16; i++) begin
      wr_en   = 2'b11;
      wr_addr = {5'(2*i + 1), 5'(2*i)};
      wr_data = {32'hC0DE_0000 + 32'(2*i + 1), 32'hC0DE_0000 + 32'(2*i)};
      issue_en   = 1'b0;
      rd_addr    = {5'(2*i + 1), 5'(2*i)};
      sample();
      advance();
    end
    idle_inputs();
    issue_en   = 1'b1;
    issue_addr = 5'd20;
    sample();
    advance();
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = {5'(2*i + 1), 5'(2*i)};
      sample();
      chk($sformatf("%s_d[r%0d]", tag, 2*i), rd_data[31:0], 32'h0);
      chk($sformatf("%s_d[r%0d]", tag, 2*i + 1), rd_data[63:32], 32'h0);
      chk($sformatf("%s_p[r%0d]", tag, 2*i), 32'(rd_pending), 32'h0);
      advance();
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [4:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        ep0;
    logic        ep1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] old_v;

    tbl[0] = '{2'b11, 5'd5, 5'd5, 32'hAAAA_0000, 32'h5555_1111, 1'b1, 5'd7, 5'd1, 5'd2,
               32'h0, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7,
               32'h5555_1111, 32'h0, 1'b0, 1'b1};
    tbl[2] = '{2'b11, 5'd9, 5'd7, 32'h0000_BEEF, 32'h0000_1234, 1'b1, 5'd9, 5'd0, 5'd5,
               32'h0, 32'h5555_1111, 1'b0, 1'b0};
    tbl[3] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd7, 5'd9,
               32'h0000_1234, 32'h0000_BEEF, 1'b0, 1'b1};
    tbl[4] = '{2'b11, 5'd12, 5'd13, 32'h1, 32'h2, 1'b0, 5'd0, 5'd0, 5'd9,
               32'h0, 32'h0000_BEEF, 1'b0, 1'b1};
    tbl[5] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd13,
               32'h1, 32'h2, 1'b0, 1'b0};

    // Reset held for two clocks
    idle_inputs();
    rd_addr = {5'd1, 5'd0};
    rst_n   = 1'b0;
    advance();
    advance();
    rst_n = 1'b1;
    rd_addr = {5'd31, 5'd5};
    sample();
    chk("reset_rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
    chk("reset_rd_pending", 32'(rd_pending), 32'h0);
    chk("reset_ready", 32'(ready), 32'h1);
    chk("reset_clear_busy", 32'(clear_busy), 32'h0);
    advance();

    // Directed table: collision, grounded r0, scoreboard
    for (int i = 0; i < 6; i++) begin
      wr_en      = tbl[i].we;
      wr_addr    = {tbl[i].wa1, tbl[i].wa0};
      wr_data    = {tbl[i].wd1, tbl[i].wd0};
      issue_en   = tbl[i].ie;
      issue_addr = tbl[i].ia;
      rd_addr    = {tbl[i].ra1, tbl[i].ra0};
      sample();
      chk($sformatf("tbl%0d_d0", i), rd_data[31:0], tbl[i].ed0);
      chk($sformatf("tbl%0d_d1", i), rd_data[63:32], tbl[i].ed1);
      chk($sformatf("tbl%0d_p0", i), 32'(rd_pending[0]), 32'(tbl[i].ep0));
      chk($sformatf("tbl%0d_p1", i), 32'(rd_pending[1]), 32'(tbl[i].ep1));
      advance();
    end
    idle_inputs();

    // Write-to-read visibility on r3
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h0000_1111};
    rd_addr = {5'd3, 5'd3};
    sample();
    advance();
    wr_data = {32'h0, 32'h0000_DEAD};
    sample();
`ifdef REGFILE_BYPASS_EN
    old_v = 32'h0000_DEAD;
`else
    old_v = 32'h0000_1111;
`endif
    chk("bypass_same_cycle", rd_data[31:0], old_v);
    advance();
    idle_inputs();
    sample();
    chk("bypass_next_cycle", rd_data[31:0], 32'h0000_DEAD);
    advance();

    // Full clear: busy length, writes dropped while busy
    fill_all();
    clear_req = 1'b1;
    sample();
    advance();
    clear_req = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      wr_en      = 2'b11;
      wr_addr    = 10'($urandom);
      wr_data    = {$urandom, $urandom};
      issue_en   = 1'b1;
      issue_addr = 5'($urandom);
      clear_req  = 1'($urandom);
      rd_addr    = 10'($urandom);
      sample();
      if (!clear_busy) break;
      n++;
      advance();
    end
    idle_inputs();
    chk("clear_busy_cycles", 32'(n), 32'd32);
    advance();
    check_all_zero("post_clear");

    // Reset during clear cycle 10
    fill_all();
    clear_req = 1'b1;
    sample();
    advance();
    clear_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rd_addr = {5'd30, 5'd29};
      sample();
      advance();
    end
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    sample();
    chk("midclear_rst_busy", 32'(clear_busy), 32'h0);
    chk("midclear_rst_ready", 32'(ready), 32'h1);
    advance();
    check_all_zero("post_rst");

    // Randomized traffic with occasional clears
    for (int c = 0; c < 400; c++) begin
      wr_en      = 2'($urandom);
      wr_addr    = 10'($urandom);
      wr_data    = {$urandom, $urandom};
      issue_en   = 1'($urandom);
      issue_addr = 5'($urandom);
      clear_req  = ($urandom_range(0, 59) == 0);
      rd_addr    = ($urandom_range(0, 3) == 0) ? {wr_addr[9:5], issue_addr} : 10'($urandom);
      sample();
      advance();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
